// File: rtl/start_screen_ctrl.sv
// Start-screen sequencer: frame/credit counting, layer enables, prompt blink, game-start pulse.
// Optional build macro START_SCREEN_FREE_PLAY_EN lets a start press in WAIT_CREDIT launch without credit.
module start_screen_ctrl #(
  parameter int REVEAL_FRAMES = 60,
  parameter int BLINK_FRAMES  = 30,
  parameter int LAUNCH_FRAMES = 90,
  parameter int OVER_FRAMES   = 180,
  parameter int MAX_CREDITS   = 9
) (
  input  logic       clk,
  input  logic       resetN,
  input  logic       startOfFrame,
  input  logic       coinKey,
  input  logic       startKey,
  input  logic       gameOver,
  output logic       startEnable,
  output logic       spaceEnable,
  output logic       creditEnable,
  output logic [3:0] creditCount,
  output logic       gameStart,
  output logic       screenActive
);

  // state          | meaning
  // TITLE_REVEAL   | title shown alone after reset
  // WAIT_CREDIT    | title + credit text, waiting for a coin
  // READY          | credit available, start prompt blinking
  // LAUNCH         | start accepted, steady prompt before play
  // PLAYING        | game running, start screen suppressed
  // GAME_OVER_HOLD | game-over screen held for a fixed time
  typedef enum logic [2:0] {
    TITLE_REVEAL, WAIT_CREDIT, READY, LAUNCH, PLAYING, GAME_OVER_HOLD
  } state_t;

  localparam logic [7:0] REVEAL_LAST = 8'(REVEAL_FRAMES - 1);
  localparam logic [7:0] BLINK_LAST  = 8'(BLINK_FRAMES - 1);
  localparam logic [7:0] LAUNCH_LAST = 8'(LAUNCH_FRAMES - 1);
  localparam logic [7:0] OVER_LAST   = 8'(OVER_FRAMES - 1);
  localparam logic [4:0] CREDIT_MAX  = 5'(MAX_CREDITS);

  state_t     state_q, state_d;
  logic       coin_prev_q, start_prev_q;
  logic [7:0] frame_cnt_q, frame_cnt_d;
  logic [3:0] credit_q, credit_d;
  logic       blink_q, blink_d;
  logic       start_en_q, start_en_d;
  logic       space_en_q, space_en_d;
  logic       credit_en_q, credit_en_d;
  logic       game_start_q, game_start_d;
  logic       screen_active_q, screen_active_d;

  logic       coin_edge, start_edge, start_accepted, blink_toggle;
  logic [4:0] credit_sum;

  assign coin_edge  = coinKey & ~coin_prev_q;
  assign start_edge = startKey & ~start_prev_q;

  always_comb begin
    state_d        = state_q;
    start_accepted = 1'b0;
    blink_toggle   = 1'b0;
    case (state_q)
      TITLE_REVEAL:
        if (startOfFrame && frame_cnt_q == REVEAL_LAST) state_d = WAIT_CREDIT;
      WAIT_CREDIT: begin
`ifdef START_SCREEN_FREE_PLAY_EN
        if (start_edge)          state_d = LAUNCH;
        else if (credit_q != 0)  state_d = READY;
`else
        if (credit_q != 0)       state_d = READY;
`endif
      end
      READY:
        if (start_edge) begin
          state_d        = LAUNCH;
          start_accepted = 1'b1;
        end else if (startOfFrame && frame_cnt_q == BLINK_LAST) begin
          blink_toggle = 1'b1;
        end
      LAUNCH:
        if (startOfFrame && frame_cnt_q == LAUNCH_LAST) state_d = PLAYING;
      PLAYING:
        if (gameOver) state_d = GAME_OVER_HOLD;
      GAME_OVER_HOLD:
        if (startOfFrame && frame_cnt_q == OVER_LAST)
          state_d = (credit_q != 0) ? READY : WAIT_CREDIT;
      default: state_d = TITLE_REVEAL;
    endcase
  end

  // In READY the frame counter doubles as the blink half-period timer.
  always_comb begin
    frame_cnt_d = frame_cnt_q;
    if (state_d != state_q || blink_toggle) frame_cnt_d = 8'd0;
    else if (startOfFrame)                  frame_cnt_d = frame_cnt_q + 8'd1;

    blink_d = blink_q;
    if (state_q != READY)  blink_d = 1'b1;
    else if (blink_toggle) blink_d = ~blink_q;

    // Deduct first, then saturate the coin increment.
    credit_sum = {1'b0, credit_q} + {4'd0, coin_edge} - {4'd0, start_accepted};
    credit_d   = (credit_sum > CREDIT_MAX) ? CREDIT_MAX[3:0] : credit_sum[3:0];
  end

  always_comb begin
    start_en_d      = 1'b0;
    space_en_d      = 1'b0;
    credit_en_d     = 1'b0;
    game_start_d    = (state_d == PLAYING) && (state_q == LAUNCH);
    screen_active_d = (state_d != PLAYING);
    case (state_d)
      TITLE_REVEAL:   space_en_d = 1'b1;
      WAIT_CREDIT:    begin space_en_d = 1'b1; credit_en_d = 1'b1; end
      READY:          begin space_en_d = 1'b1; credit_en_d = 1'b1; start_en_d = blink_d; end
      LAUNCH:         begin space_en_d = 1'b1; credit_en_d = 1'b1; start_en_d = 1'b1; end
      GAME_OVER_HOLD: space_en_d = 1'b1;
      default:        ;
    endcase
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_q         <= TITLE_REVEAL;
      coin_prev_q     <= 1'b0;
      start_prev_q    <= 1'b0;
      frame_cnt_q     <= 8'd0;
      credit_q        <= 4'd0;
      blink_q         <= 1'b1;
      start_en_q      <= 1'b0;
      space_en_q      <= 1'b0;
      credit_en_q     <= 1'b0;
      game_start_q    <= 1'b0;
      screen_active_q <= 1'b0;
    end else begin
      state_q         <= state_d;
      coin_prev_q     <= coinKey;
      start_prev_q    <= startKey;
      frame_cnt_q     <= frame_cnt_d;
      credit_q        <= credit_d;
      blink_q         <= blink_d;
      start_en_q      <= start_en_d;
      space_en_q      <= space_en_d;
      credit_en_q     <= credit_en_d;
      game_start_q    <= game_start_d;
      screen_active_q <= screen_active_d;
    end
  end

  assign startEnable  = start_en_q;
  assign spaceEnable  = space_en_q;
  assign creditEnable = credit_en_q;
  assign creditCount  = credit_q;
  assign gameStart    = game_start_q;
  assign screenActive = screen_active_q;

endmodule

// File: tb/tb_start_screen_ctrl.sv
// Directed bench for start_screen_ctrl; outputs sampled 1 time unit after each rising clk edge.
module tb_start_screen_ctrl;

  logic       clk = 1'b0;
  logic       resetN, startOfFrame, coinKey, startKey, gameOver;
  logic       startEnable, spaceEnable, creditEnable, gameStart, screenActive;
  logic [3:0] creditCount;
  int         n_assert = 0;
  int         n_fail   = 0;

  always #5 clk = ~clk;

  start_screen_ctrl #(
    .REVEAL_FRAMES(4), .BLINK_FRAMES(2), .LAUNCH_FRAMES(3), .OVER_FRAMES(5), .MAX_CREDITS(9)
  ) dut (
    .clk(clk), .resetN(resetN), .startOfFrame(startOfFrame), .coinKey(coinKey),
    .startKey(startKey), .gameOver(gameOver), .startEnable(startEnable),
    .spaceEnable(spaceEnable), .creditEnable(creditEnable), .creditCount(creditCount),
    .gameStart(gameStart), .screenActive(screenActive)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Idle cycle, then a one-cycle startOfFrame; returns just after the pulse edge.
  task automatic frame();
    step();
    startOfFrame = 1'b1;
    step();
    startOfFrame = 1'b0;
  endtask

  task automatic coin_press();
    coinKey = 1'b1;
    step();
    coinKey = 1'b0;
    step();
  endtask

  // Expected vector order: start, space, credit, gameStart, screenActive, creditCount.
  task automatic check(input string tag, input logic st, input logic sp, input logic cr,
                       input logic gs, input logic sa, input logic [3:0] cnt);
    logic [8:0] obs, exp;
    obs = {startEnable, spaceEnable, creditEnable, gameStart, screenActive, creditCount};
    exp = {st, sp, cr, gs, sa, cnt};
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed st/sp/cr/gs/sa/cnt=%b expected %b", tag, obs, exp);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    resetN = 1'b0; startOfFrame = 1'b0; coinKey = 1'b0; startKey = 1'b0; gameOver = 1'b0;
    step(); step();
    check("reset_state", 0, 0, 0, 0, 0, 4'd0);
    resetN = 1'b1;
    step();
    check("after_release", 0, 1, 0, 0, 1, 4'd0);

    frame(); frame(); frame();
    check("reveal_3_frames", 0, 1, 0, 0, 1, 4'd0);
    frame();
    check("reveal_done_wait_credit", 0, 1, 1, 0, 1, 4'd0);

    coinKey = 1'b1;
    step();
    check("coin_edge_credit1", 0, 1, 1, 0, 1, 4'd1);
    step();
    check("ready_entered", 1, 1, 1, 0, 1, 4'd1);
    repeat (8) step();
    coinKey = 1'b0;
    step();
    check("held_coin_single", 1, 1, 1, 0, 1, 4'd1);

    frame(); check("blink_f1", 1, 1, 1, 0, 1, 4'd1);
    frame(); check("blink_f2", 0, 1, 1, 0, 1, 4'd1);
    frame(); check("blink_f3", 0, 1, 1, 0, 1, 4'd1);
    frame(); check("blink_f4", 1, 1, 1, 0, 1, 4'd1);

    startKey = 1'b1;
    step();
    check("start_to_launch", 1, 1, 1, 0, 1, 4'd0);
    step();
    startKey = 1'b0;
    frame(); frame();
    check("launch_2_frames", 1, 1, 1, 0, 1, 4'd0);
    frame();
    check("game_start_pulse", 0, 0, 0, 1, 0, 4'd0);
    step();
    check("game_start_one_cycle", 0, 0, 0, 0, 0, 4'd0);

    coin_press(); coin_press();
    check("coins_in_playing", 0, 0, 0, 0, 0, 4'd2);
    gameOver = 1'b1;
    step();
    gameOver = 1'b0;
    check("game_over_hold", 0, 1, 0, 0, 1, 4'd2);
    frame(); frame(); frame(); frame();
    check("hold_4_frames", 0, 1, 0, 0, 1, 4'd2);
    frame();
    check("hold_to_ready", 1, 1, 1, 0, 1, 4'd2);
    gameOver = 1'b1;
    step();
    gameOver = 1'b0;
    step();
    check("gameover_ignored_ready", 1, 1, 1, 0, 1, 4'd2);

    repeat (12) coin_press();
    check("credit_saturate", 1, 1, 1, 0, 1, 4'd9);
    coinKey = 1'b1; startKey = 1'b1;
    step();
    check("coin_start_same_cycle", 1, 1, 1, 0, 1, 4'd9);
    coinKey = 1'b0; startKey = 1'b0;
    frame(); frame();
    check("launch_steady_prompt", 1, 1, 1, 0, 1, 4'd9);

    #2 resetN = 1'b0;
    #1;
    check("async_reset_mid_launch", 0, 0, 0, 0, 0, 4'd0);
    step();
    resetN = 1'b1;
    step();
    check("title_after_reset", 0, 1, 0, 0, 1, 4'd0);
    frame(); frame(); frame(); frame();
    check("wait_credit_again", 0, 1, 1, 0, 1, 4'd0);

    startKey = 1'b1;
    step();
    startKey = 1'b0;
`ifdef START_SCREEN_FREE_PLAY_EN
    check("free_play_launch", 1, 1, 1, 0, 1, 4'd0);
    frame(); frame(); frame();
    check("free_play_game_start", 0, 0, 0, 1, 0, 4'd0);
`else
    check("start_ignored_no_credit", 0, 1, 1, 0, 1, 4'd0);
    step(); step();
    check("still_wait_credit", 0, 1, 1, 0, 1, 4'd0);
    coin_press();
    check("coin_after_ignored_start", 1, 1, 1, 0, 1, 4'd1);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/start_screen_ctrl.md
# start_screen_ctrl

Sequencer for the start-screen layers. It counts frames and credits, decides which start-screen layer (title, "space invaders" text, credit text) may request drawing, blinks the start prompt, and issues a one-cycle game-start pulse. It sits upstream of the start-screen priority mux: each layer's drawing request is ANDed with the matching enable from this block. The mux's combined drawing-request output is suppressed during play by `screenActive`.

## Interface
Parameters:
- `REVEAL_FRAMES`, default 60: frames the title is shown alone after reset.
- `BLINK_FRAMES`, default 30: frames per half-period of the start-prompt blink.
- `LAUNCH_FRAMES`, default 90: frames of steady prompt between start press and `gameStart`.
- `OVER_FRAMES`, default 180: frames to hold the game-over screen.
- `MAX_CREDITS`, default 9: credit saturation value, range 1..15.

All frame parameters are in the range 1..255.

Ports:
- `clk`, in, 1: system clock.
- `resetN`, in, 1: reset, asynchronous, active-low.
- `startOfFrame`, in, 1: one-cycle pulse per video frame.
- `coinKey`, in, 1: coin button level, already synchronous to `clk`.
- `startKey`, in, 1: start button level, already synchronous to `clk`.
- `gameOver`, in, 1: one-cycle pulse from the game core.
- `startEnable`, out, 1: gates the start-prompt layer.
- `spaceEnable`, out, 1: gates the "space invaders" title layer.
- `creditEnable`, out, 1: gates the credit text layer.
- `creditCount`, out, 4: current credits, fed to the credit text generator.
- `gameStart`, out, 1: one-cycle pulse when play begins.
- `screenActive`, out, 1: high in every state except PLAYING.

## Operation
- Rising-edge detect on `coinKey` and `startKey` using one registered previous value each. A held key produces a single event. The previous-value registers reset to 0, so a key held through reset release counts as one edge.
- 8-bit frame counter:
  - Cleared on every state change.
  - Incremented on `startOfFrame`.
  - The state's limit is reached when a pulse arrives with counter == limit−1.
- Credits:
  - Every state: `next = min(credit + coinEdge − startAccepted, MAX_CREDITS)`. The decrement is applied before the saturating increment.
  - Coins are counted in all states, including PLAYING.
- FSM states and transitions:
  - TITLE_REVEAL (reset state) → WAIT_CREDIT after `REVEAL_FRAMES` frames. Enables: space only.
  - WAIT_CREDIT → READY when credit ≠ 0. Enables: space and credit. A start edge here is ignored.
  - READY → LAUNCH on a start edge. The start is accepted and one credit is deducted. Enables: space and credit; start enable = blink.
    - Blink is 1 on entry and toggles every `BLINK_FRAMES` frames.
  - LAUNCH → PLAYING after `LAUNCH_FRAMES` frames. `gameStart` = 1 on the entry cycle. Enables: all three, steady.
  - PLAYING → GAME_OVER_HOLD on `gameOver`. Enables: none. `screenActive` = 0.
  - GAME_OVER_HOLD → WAIT_CREDIT, or directly to READY if credit ≠ 0, after `OVER_FRAMES` frames. Enables: space only.
- `gameOver` outside PLAYING is ignored. Start edges outside READY are ignored.

## Timing
- All outputs are registered and decoded from the next state, so they change on the same edge as the state register.
- Reset values: state TITLE_REVEAL, credit 0, counter 0, blink 1, all outputs 0 including `screenActive`. On the first `clk` edge after release, `spaceEnable` = 1 and `screenActive` = 1.
- Latency:
  - Coin edge to `creditCount` update: 1 cycle after the key rises.
  - WAIT_CREDIT → READY: 1 further cycle.
  - Start key rise to LAUNCH, with enables and credit updated: 1 cycle.
- Simultaneous events:
  - Coin and start edges in the same cycle in READY: credit is unchanged, unless credit == `MAX_CREDITS`, in which case the result is `MAX_CREDITS`. The state goes to LAUNCH.
  - `startOfFrame` coincident with a state change: the pulse is not counted in the new state.
- Reset asserted mid-operation: all registers clear immediately and asynchronously, and the credits are lost.

## Configuration
- `START_SCREEN_FREE_PLAY_EN`
  - Defined: WAIT_CREDIT treats a start edge as accepted and goes to LAUNCH with no credit deduction. The credit layer stays enabled. `creditCount` still tracks coins.
  - Undefined: start is ignored without credit, as described in Operation.

## Test plan
Benches use `REVEAL_FRAMES`=4, `BLINK_FRAMES`=2, `LAUNCH_FRAMES`=3, `OVER_FRAMES`=5 and `MAX_CREDITS`=9 unless noted.
- Reset release then 4 `startOfFrame` pulses → `spaceEnable`=1 throughout. `creditEnable` rises on the cycle after the 4th pulse is sampled. `startEnable`=0.
- One coin press (key held 10 cycles) in WAIT_CREDIT → `creditCount`=1, not 10. READY is entered. `startEnable` reads 1,1,0,0,1 across 5 frames.
- Start press with credit 1 → `creditCount`=0 and LAUNCH on the next cycle. After 3 frames, `gameStart` is a single-cycle pulse, all enables are 0 and `screenActive`=0.
- 12 coin presses → `creditCount` saturates at 9. A same-cycle coin and start in READY → `creditCount` stays 9 (reset to credit 9 first) → LAUNCH.
- `gameOver` in PLAYING with credit 2 → GAME_OVER_HOLD with `spaceEnable` only. After 5 frames the state is READY. `gameOver` in READY causes no change.
- `resetN` pulsed low during LAUNCH → outputs drop to 0 immediately, credit = 0 and the state is TITLE_REVEAL. With `START_SCREEN_FREE_PLAY_EN` defined, a start edge at credit 0 in WAIT_CREDIT → LAUNCH.
